// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state net with a dead time before each new owner.
// The one-hot enables drive the bufif1 gates and double as the grant.
module tristate_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DEAD_CYC  = 2,
    parameter int MAX_GRANT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         en,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     bus_busy,
    output logic                     bus_dead
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
    localparam logic [7:0] HOLD_SAT = (MAX_GRANT == 0) ? 8'd255 : 8'(MAX_GRANT);

    // bus_busy / bus_dead are a registered decode of state (both low means IDLE).
    typedef enum logic [1:0] {
        S_DEAD  = 2'd0,
        S_IDLE  = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [3:0]         dead_cnt, dead_cnt_n;
    logic [7:0]         hold_cnt, hold_cnt_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   owner_n;
    logic [N_REQ-1:0]   en_n;
    logic               busy_n, dead_n;

    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               others_req;
    logic               preempt;
    logic               grant_go;

    // Scan from the highest offset down so the nearest requester after ptr wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N_REQ]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'((int'(ptr) + i) % N_REQ);
            end
        end
    end

    assign others_req = |(req & ~(ONE << owner));
    assign preempt    = (MAX_GRANT != 0) && (hold_cnt == 8'(MAX_GRANT)) && others_req;

    always_comb begin
        state_n    = state;
        dead_cnt_n = dead_cnt;
        hold_cnt_n = hold_cnt;
        ptr_n      = ptr;
        owner_n    = owner;
        en_n       = en;
        grant_go   = 1'b0;

        case (state)
            S_DEAD: begin
                en_n = '0;
                if (dead_cnt <= 4'd1) begin
                    dead_cnt_n = '0;
                    if (win_valid) grant_go = 1'b1;
                    else           state_n  = S_IDLE;
                end else begin
                    dead_cnt_n = dead_cnt - 4'd1;
                end
            end
            S_IDLE: begin
                en_n = '0;
                if (win_valid) grant_go = 1'b1;
            end
            S_GRANT: begin
                // Voluntary release and preemption share one exit path, so a
                // coincident pair produces a single dead interval.
                if (!req[owner] || preempt) begin
                    state_n    = S_DEAD;
                    en_n       = '0;
                    dead_cnt_n = 4'(DEAD_CYC);
                    hold_cnt_n = '0;
                end else if (hold_cnt < HOLD_SAT) begin
                    hold_cnt_n = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_n    = S_DEAD;
                en_n       = '0;
                dead_cnt_n = 4'(DEAD_CYC);
            end
        endcase

        if (grant_go) begin
            state_n    = S_GRANT;
            en_n       = ONE << win_idx;
            owner_n    = win_idx;
            hold_cnt_n = 8'd1;
            ptr_n      = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end

        busy_n = (state_n == S_GRANT);
        dead_n = (state_n == S_DEAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_DEAD;
            dead_cnt <= 4'(DEAD_CYC);
            hold_cnt <= '0;
            ptr      <= '0;
            owner    <= '0;
            en       <= '0;
            bus_busy <= 1'b0;
            bus_dead <= 1'b1;
        end else begin
            state    <= state_n;
            dead_cnt <= dead_cnt_n;
            hold_cnt <= hold_cnt_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            en       <= en_n;
            bus_busy <= busy_n;
            bus_dead <= dead_n;
        end
    end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Shares one tri-state bus between `N_REQ` requesters by driving the per-driver `bufif1` enable lines, one-hot, so that at most one driver is ever enabled. Between any two owners it inserts a programmable break-before-make dead time, during which every enable is low. That dead time covers the gate-level turn-off-to-Z delay of the buffers, so no two drivers overlap on the net. Selection among requesters is round-robin, with optional preemption after a maximum hold time.

## Interface
- `N_REQ`, 4: number of requesters/drivers; legal range 2..8.
- `DEAD_CYC`, 2: number of all-enables-low cycles between owners; legal range 1..15.
- `MAX_GRANT`, 8: number of cycles an owner may hold the bus while others wait; 0 disables preemption; legal range 0..255.

- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  N_REQ  per-requester bus request, level-sensitive; held high while the requester wants the bus.
- `en`  output  N_REQ  registered one-hot-or-zero enables to the `bufif1` drivers; doubles as the grant.
- `owner`  output  $clog2(N_REQ)  index of the current or last owner.
- `bus_busy`  output  1  high in GRANT.
- `bus_dead`  output  1  high in DEAD.

## Operation
- **FSM states:** DEAD, IDLE, GRANT. All outputs are registered.
- **Reset:** state=DEAD, dead counter loaded to `DEAD_CYC`, hold counter=0, `en`=0, `owner`=0, `bus_busy`=0, `bus_dead`=1. The round-robin pointer is set so that index 0 has top priority.
- **DEAD:**
  - `en`=0; the counter decrements each cycle.
  - On the edge ending the last dead cycle: if any `req` bit is high, go to GRANT with the winner; otherwise go to IDLE.
- **IDLE:**
  - `en`=0.
  - On the first edge that samples any `req` high, go to GRANT. `en` becomes one-hot for the winner on that edge.
- **Arbitration:**
  - Round-robin. The search starts at `owner`+1 mod `N_REQ`. After reset it starts at 0.
  - The winner is the first set `req` bit found. `owner` updates on the same edge as `en`.
- **GRANT:**
  - The hold counter starts at 1 in the first granted cycle and increments each cycle, saturating at `MAX_GRANT`.
  - **Voluntary release:** when `req[owner]` is sampled low, the next edge clears `en` and enters DEAD.
  - **Preemption:** when `MAX_GRANT`≠0, the hold counter equals `MAX_GRANT`, and any other `req` bit is high, the next edge clears `en` and enters DEAD. If only the owner is requesting, the grant continues indefinitely.
- **Back-to-back:** a requester that drops `req` and re-raises it during DEAD competes normally. Round-robin order still favours the other requesters.
- **Invariants:**
  - `$countones(en)` ≤ 1 at all times.
  - `en`≠0 only in GRANT.
  - `en` never changes directly from one non-zero value to a different non-zero value.

## Timing
- Between two owners there are exactly `DEAD_CYC` cycles with `en`=0, provided a request is pending at the end of DEAD.
- Grant latency:
  - From IDLE: `en` is high in the cycle after the edge that samples `req`.
  - From DEAD: `en` is high immediately after the last dead cycle.
- Release latency: one edge after `req[owner]` is sampled low.
- With a waiting requester, the bus stays granted for exactly `MAX_GRANT` cycles.
- After `rst` deasserts, `en` stays 0 for `DEAD_CYC` cycles, so the bus is guaranteed Z from reset.
- **Reset mid-operation:** an edge with `rst` high forces reset values on that edge, regardless of state. A partially elapsed dead time is reloaded to the full `DEAD_CYC`.
- **Simultaneous events:** the same edge sees the owner drop `req` and the preemption threshold reached. The outcome is a single release into DEAD; there is no double-count.

## Test plan
All scenarios use `N_REQ`=4, `DEAD_CYC`=2, `MAX_GRANT`=8, and check the one-hot/no-overlap invariant every cycle.
- **Reset exit:** hold `rst` high 3 cycles with `req`=4'b0001, then release. Required: `en`=0 and `bus_dead`=1 for 2 cycles, then `en`=4'b0001, `owner`=0, `bus_busy`=1.
- **Handoff:** `req`=4'b0101 with owner 0, then drop `req[0]`. Required: `en` goes to 0 one edge later, stays 0 for exactly 2 cycles, then `en`=4'b0100, `owner`=2.
- **Preemption:** hold `req[0]`; raise `req[1]` in the first granted cycle. Required: `en`=4'b0001 for exactly 8 cycles, 0 for 2 cycles, then 4'b0010.
- **No preemption when alone:** hold `req`=4'b1000 for 20 cycles after grant. Required: `en`=4'b1000 all 20 cycles and `bus_dead`=0.
- **Fairness:** hold `req`=4'b1111 continuously. Required: owner sequence 0,1,2,3,0; each grant lasts 8 cycles, separated by 2 dead cycles.
- **Reset mid-grant:** assert `rst` for 1 cycle while `en`=4'b0100. Required: after that edge `en`=0, `owner`=0, `bus_dead`=1. With `req`=4'b0100 still high, `en`=4'b0100 returns exactly 2 cycles after reset release.
